spi_master: RTL

- SPI master controller: drives s_clk, slave_sel and master_out toward an SPI slave, and captures the slave's serial output.
- Serializes bytes from the main controller MSB-first and returns each received byte.
- Holds slave_sel low across multi-byte bursts and enforces a minimum deselect gap between transactions.
- Sits between the main controller and the external SPI link to the peer device.

---
 rtl/spi_master.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// SPI master: serializes bytes MSB-first, holds select across bursts and
// enforces a minimum deselect gap between transactions.
module spi_master #(
  parameter int unsigned HALF_DIV   = 2,
  parameter int unsigned GAP_HALVES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       s_clk,
  output logic       slave_sel,
  output logic       master_out,
  input  logic       master_in
);

  localparam int unsigned GapCycles = GAP_HALVES * HALF_DIV;
  localparam int unsigned CntMax    = (GapCycles > HALF_DIV) ? GapCycles : HALF_DIV;
  localparam int unsigned CntW      = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] HalfEnd = CntW'(HALF_DIV - 1);
  localparam logic [CntW-1:0] GapEnd  = CntW'((GapCycles > 0) ? GapCycles - 1 : 0);

  typedef enum logic [2:0] {
    StIdle, StLead, StHigh, StLow, StStall, StTail, StGap
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            last_q, last_d;
  logic            sclk_q, sclk_d;
  logic            sel_q, sel_d;
  logic            mo_q, mo_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            live_q;
  logic            accept;
  logic            half_end;

  assign tx_ready   = live_q & ((state_q == StIdle) | (state_q == StStall));
  assign accept     = tx_valid & tx_ready;
  assign half_end   = (cnt_q == HalfEnd);
  assign busy       = (state_q != StIdle);
  assign s_clk      = sclk_q;
  assign slave_sel  = sel_q;
  assign master_out = mo_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    last_d     = last_q;
    sclk_d     = sclk_q;
    sel_d      = sel_q;
    mo_d       = mo_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;

    unique case (state_q)
      StIdle, StStall: begin
        if (accept) begin
          shift_d   = tx_data;
          last_d    = tx_last;
          bit_cnt_d = 4'd0;
          sel_d     = 1'b0;
          sclk_d    = 1'b0;
          mo_d      = tx_data[7];
          cnt_d     = '0;
          state_d   = StLead;
          // Accept on STALL entry: the entry cycle already served as one low
          // clk of the lead, keeping the s_clk cadence continuous.
          if (state_q == StStall && rx_valid_q) begin
            if (HALF_DIV == 1) begin
              sclk_d  = 1'b1;
              state_d = StHigh;
            end else begin
              cnt_d = CntW'(1);
            end
          end
        end
      end
      StLead, StLow: begin
        if (half_end) begin
          sclk_d  = 1'b1;
          cnt_d   = '0;
          state_d = StHigh;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHigh: begin
        if (half_end) begin
          sclk_d    = 1'b0;
          cnt_d     = '0;
          shift_d   = {shift_q[6:0], master_in};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            rx_data_d  = shift_d;
            rx_valid_d = 1'b1;
            state_d    = last_q ? StTail : StStall;
          end else begin
            mo_d    = shift_d[7];
            state_d = StLow;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StTail: begin
        if (half_end) begin
          sel_d   = 1'b1;
          sclk_d  = 1'b1;
          mo_d    = 1'b0;
          cnt_d   = '0;
          state_d = (GapCycles == 0) ? StIdle : StGap;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == GapEnd) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      last_q     <= 1'b0;
      sclk_q     <= 1'b1;
      sel_q      <= 1'b1;
      mo_q       <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      sclk_q     <= sclk_d;
      sel_q      <= sel_d;
      mo_q       <= mo_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      live_q     <= 1'b1;
    end
  end

endmodule
